// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback stage.
package alu_writeback_pkg;

  localparam int unsigned WB_DATA_WIDTH = 8;
  localparam int unsigned WB_ADDR_WIDTH = 5;
  localparam int unsigned OPSEL_WIDTH   = 4;

  // ALU operation codes; 11..15 are undefined and take the single-byte path.
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_NONE  = 4'd0;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_ADD   = 4'd1;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_ADC   = 4'd2;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_SUB   = 4'd3;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_SBC   = 4'd4;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_AND   = 4'd5;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_OR    = 4'd6;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_EOR   = 4'd7;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_MUL   = 4'd8;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_MULS  = 4'd9;
  localparam logic [OPSEL_WIDTH-1:0] OPSEL_MULSU = 4'd10;

  // Writeback sequencer states.
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ONE  = 2'd1,
    WB_LO   = 2'd2,
    WB_HI   = 2'd3
  } wb_state_t;

  // True for operations returning a 16-bit product.
  function automatic logic is_mul_op(input logic [OPSEL_WIDTH-1:0] op);
    return (op == OPSEL_MUL) || (op == OPSEL_MULS) || (op == OPSEL_MULSU);
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU result bundle handshake between the ALU (master) and writeback (slave).
interface alu_writeback_if
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
);
  logic                    valid_in;
  logic                    ready_out;
  logic [OPSEL_WIDTH-1:0]  opsel;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic [2*DATA_WIDTH-1:0] mul_out;
  logic [DATA_WIDTH-1:0]   flags_in;
  logic                    wb_en;
  logic                    sreg_en;

  modport master (
    output valid_in, opsel, rd_addr, alu_out, mul_out, flags_in, wb_en, sreg_en,
    input  ready_out
  );

  modport slave (
    input  valid_in, opsel, rd_addr, alu_out, mul_out, flags_in, wb_en, sreg_en,
    output ready_out
  );
endinterface

// File: rtl/alu_writeback.sv
// Sequences ALU results into a single-write-port register file and owns SREG.
// A 16-bit product is written as two consecutive byte writes (low, then high).
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int unsigned            ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  MUL_LO_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0]  MUL_HI_ADDR = ADDR_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0]  SREG_RESET  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_writeback_if.slave        bus,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [DATA_WIDTH-1:0] sreg,
  output logic                  done
);

  wb_state_t             state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_d, done_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d, sreg_d;
  // Only the parts of the bundle needed after the accept cycle are captured;
  // the first write of every bundle is registered straight from the inputs.
  logic                  wb_en_q, wb_en_d;
  logic [DATA_WIDTH-1:0] mul_hi_q, mul_hi_d;
  logic                  accept;

  assign accept        = bus.valid_in & ready_q;
  assign bus.ready_out = ready_q;

  // Next state and next registered outputs.
  always_comb begin
    state_d  = WB_IDLE;
    ready_d  = 1'b1;
    we_d     = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    done_d   = 1'b0;
    sreg_d   = sreg;
    wb_en_d  = wb_en_q;
    mul_hi_d = mul_hi_q;

    case (state_q)
      WB_LO: begin
        state_d = WB_HI;
        we_d    = wb_en_q;
        waddr_d = wb_en_q ? MUL_HI_ADDR : '0;
        wdata_d = wb_en_q ? mul_hi_q : '0;
        done_d  = 1'b1;
      end
      default: begin
        if (accept) begin
          wb_en_d  = bus.wb_en;
          mul_hi_d = bus.mul_out[2*DATA_WIDTH-1:DATA_WIDTH];
          if (bus.sreg_en) sreg_d = bus.flags_in;
          we_d = bus.wb_en;
          if (is_mul_op(bus.opsel)) begin
            state_d = WB_LO;
            ready_d = 1'b0;
            waddr_d = bus.wb_en ? MUL_LO_ADDR : '0;
            wdata_d = bus.wb_en ? bus.mul_out[DATA_WIDTH-1:0] : '0;
          end else begin
            state_d = WB_ONE;
            done_d  = 1'b1;
            waddr_d = bus.wb_en ? bus.rd_addr : '0;
            wdata_d = bus.wb_en ? bus.alu_out : '0;
          end
        end
      end
    endcase
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WB_IDLE;
      ready_q  <= 1'b1;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      done     <= 1'b0;
      sreg     <= SREG_RESET;
      wb_en_q  <= 1'b0;
      mul_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rf_we    <= we_d;
      rf_waddr <= waddr_d;
      rf_wdata <= wdata_d;
      done     <= done_d;
      sreg     <= sreg_d;
      wb_en_q  <= wb_en_d;
      mul_hi_q <= mul_hi_d;
    end
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Consumer end of the ALU result interface. Accepts one ALU result per handshake: 8-bit result, 16-bit multiply product, flags and destination info.
- Sequences the writes into the single-write-port register file and owns the architectural status register (SREG).
- Sits between the ALU and the register file/control unit. Replaces direct combinational writeback so MUL/MULS/MULSU can return a 16-bit product through an 8-bit write port.

Parameters:
- DATA_WIDTH, 8, register/result width.
- ADDR_WIDTH, 5, register file address width.
- MUL_LO_ADDR, 0, destination of product low byte.
- MUL_HI_ADDR, 1, destination of product high byte.
- SREG_RESET, 8'h00, SREG value after reset.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  result bundle valid; held stable until accepted.
- ready_out  out  1  block can accept a bundle this cycle.
- opsel  in  `OPSEL_COUNT  ALU operation of the bundle.
- rd_addr  in  ADDR_WIDTH  destination register for 8-bit results.
- alu_out  in  DATA_WIDTH  ALU `out`.
- mul_out  in  2*DATA_WIDTH  ALU `mul_out`.
- flags_in  in  DATA_WIDTH  ALU `flags_out`.
- wb_en  in  1  write the result to the register file.
- sreg_en  in  1  commit flags_in to SREG.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  DATA_WIDTH  register file write data.
- sreg  out  DATA_WIDTH  architectural status register; feeds the ALU flags_in on the next op.
- done  out  1  one-cycle pulse on the last writeback cycle of a bundle.

Behaviour:
- Accept: valid_in & ready_out sampled at a rising edge. The bundle is captured into internal registers; inputs are don't-care afterwards.
- is_mul = opsel is `OPSEL_MUL, `OPSEL_MULS or `OPSEL_MULSU. Every other code, including `OPSEL_NONE and undefined codes, is treated as a single-byte result.
- States:
  - IDLE: ready_out=1, rf_we=0, done=0.
  - WB: single-byte writeback. rf_we=wb_en_q, rf_waddr=rd_addr_q, rf_wdata=alu_out_q, done=1, ready_out=1.
  - WB_LO: rf_we=wb_en_q, rf_waddr=MUL_LO_ADDR, rf_wdata=mul_q[7:0], done=0, ready_out=0.
  - WB_HI: rf_we=wb_en_q, rf_waddr=MUL_HI_ADDR, rf_wdata=mul_q[15:8], done=1, ready_out=1.
- Transitions:
  - From IDLE, WB or WB_HI: accept with is_mul goes to WB_LO; accept with !is_mul goes to WB; no accept goes to IDLE.
  - WB_LO always goes to WB_HI.
- Latency:
  - Single-byte op: write visible in the cycle after the accept edge.
  - MUL: two consecutive write cycles, low byte then high byte.
  - Back-to-back accepts give one bundle per cycle for single-byte ops and one per two cycles for MUL. No bubble cycles.
- SREG:
  - Updated at the accept edge when sreg_en=1: sreg <= flags_in.
  - Otherwise held. Updates exactly once per bundle, never on WB_LO/WB_HI edges.
  - New flags are therefore visible in the same cycle as the first writeback cycle.
- wb_en=0: states are still traversed with the same timing and done still pulses; rf_we stays 0.
- wb_en=0 and sreg_en=0: the bundle is a pure NOP that still takes 1 or 2 cycles.
- rf_waddr/rf_wdata are 0 whenever rf_we=0. No X on outputs.
- valid_in while in WB_LO: ignored (ready_out=0). The producer must hold the bundle.
- Reset:
  - state=IDLE, sreg=SREG_RESET, rf_we=0, rf_waddr=0, rf_wdata=0, done=0, captured registers=0. ready_out=1 in the first cycle after reset.
  - Reset asserted in WB_LO: high byte is never written and done is not pulsed.
  - Reset has priority over a simultaneous accept.
- Widths: mul_q[15:8] maps to bits [2*DATA_WIDTH-1:DATA_WIDTH] in general; no arithmetic is performed in this block.

Decomposition:
- defines.vh (shared): existing `OPSEL_* and `FLAGS_* codes; add `WB_IDLE, `WB_ONE, `WB_LO, `WB_HI state encodings (2 bits) and `MUL_LO_ADDR/`MUL_HI_ADDR defaults.
- No sub-module. FSM, capture registers and SREG sit in one module.

Test Plan:
- ADD, rd_addr=5, alu_out=8'h3C, flags_in=8'h02, wb_en=sreg_en=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=8'h3C, done=1, sreg=8'h02; following cycle (no valid) rf_we=0.
- MUL, mul_out=16'hBEEF, wb_en=1 -> cycle1 addr 0 data 8'hEF, ready_out=0, done=0; cycle2 addr 1 data 8'hBE, done=1, ready_out=1.
- Back-to-back: ADD (r3=8'h11), then MUL (16'h1234) presented in the WB cycle, then OR (r4=8'h55) held valid -> writes r3/11, r0/34, r1/12, r4/55 on four consecutive cycles; OR is accepted only at the WB_HI edge.
- wb_en=0, sreg_en=1, flags_in=8'h81 -> rf_we stays 0, done pulses once, sreg=8'h81. Then wb_en=1, sreg_en=0, flags_in=8'hFF -> sreg stays 8'h81.
- Reset asserted in the WB_LO cycle of a MUL (16'hA5A5) -> no write to addr 1, done never pulses, sreg=SREG_RESET, ready_out=1 in the first cycle after reset deasserts.
- Undefined opsel (all ones) with alu_out=8'h77, rd_addr=9 -> single-byte path: r9=8'h77 in one cycle, outputs never X.
